// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared definitions for the MEM pipeline stage.
//   DATA_W        : datapath width
//   wb_sel_t      : write-back source select encodings (WBdata field)
//   wait_state_t  : load-wait FSM states (used only when MEM_WAIT_EN is defined)
package mem_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_NPC = 2'b10,
    WB_RSV = 2'b11   // reserved, behaves as WB_ALU
  } wb_sel_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- bundle of EX/MEM inputs, MEM/WB outputs and forwarding taps.
//   master : pipeline side (drives EX/MEM fields, observes MEM/WB and taps)
//   slave  : MEM stage side
interface mem_stage_if;
  import mem_stage_pkg::*;

  // EX/MEM register fields
  logic              RegWr_EX;
  logic              MemWr_EX;
  logic              MemRd_EX;
  logic [1:0]        WBdata_EX;
  logic [DATA_W-1:0] ALUout_EX;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] npc3;
  logic [REG_W-1:0]  rd3;
  logic              RPzero_EX;

  // MEM/WB register outputs
  logic              RegWr_WB;
  logic [REG_W-1:0]  rd4;
  logic [DATA_W-1:0] WBvalue_WB;
  logic              RPzero_WB;

  // combinational taps for hazard/forwarding logic
  logic [REG_W-1:0]  Rd_MEM;
  logic              RegWrite_MEM;
  logic [DATA_W-1:0] Fwd_MEM;
  logic              Stall_MEM;

  modport master (
    output RegWr_EX, MemWr_EX, MemRd_EX, WBdata_EX, ALUout_EX, D, npc3, rd3, RPzero_EX,
    input  RegWr_WB, rd4, WBvalue_WB, RPzero_WB, Rd_MEM, RegWrite_MEM, Fwd_MEM, Stall_MEM
  );

  modport slave (
    input  RegWr_EX, MemWr_EX, MemRd_EX, WBdata_EX, ALUout_EX, D, npc3, rd3, RPzero_EX,
    output RegWr_WB, rd4, WBvalue_WB, RPzero_WB, Rd_MEM, RegWrite_MEM, Fwd_MEM, Stall_MEM
  );
endinterface

// File: rtl/mem_stage_datamemo.sv
// DataMemo -- word-addressed data memory, synchronous write, combinational read.
//   clk   : write clock
//   we    : write enable (write on rising edge)
//   re    : read enable; rdata is 0 when low
//   addr  : word address
//   wdata : write data
//   rdata : read data (returns pre-write contents during a same-cycle write)
// Contents are never reset.
module DataMemo
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = re ? mem[addr] : '0;

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- MEM pipeline stage: data memory access, write-back select,
// MEM/WB register and forwarding taps.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-high reset (memory contents are kept)
//   bus   : mem_stage_if.slave (EX/MEM inputs, MEM/WB outputs, taps, Stall_MEM)
// Build option MEM_WAIT_EN: loads take two cycles through an IDLE/WAIT FSM
// that raises Stall_MEM in the first cycle; otherwise Stall_MEM is 0.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ADDR_W    = 6
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  logic              mem_wr;
  logic              reg_wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] sel_value;
  logic              stall;
  logic              bubble;
  logic              unused_addr_hi;

  assign mem_wr         = bus.MemWr_EX & ~bus.RPzero_EX;
  assign reg_wr         = bus.RegWr_EX & ~bus.RPzero_EX;
  assign addr           = bus.ALUout_EX[ADDR_W-1:0];
  assign unused_addr_hi = ^bus.ALUout_EX[DATA_W-1:ADDR_W];

  DataMemo #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_datamemo (
    .clk   (clk),
    .we    (mem_wr),
    .re    (bus.MemRd_EX),
    .addr  (addr),
    .wdata (bus.D),
    .rdata (rd_data)
  );

  always_comb begin
    sel_value = bus.ALUout_EX;
    case (wb_sel_t'(bus.WBdata_EX))
      WB_MEM:  sel_value = rd_data;
      WB_NPC:  sel_value = bus.npc3;
      default: sel_value = bus.ALUout_EX;
    endcase
  end

`ifdef MEM_WAIT_EN
  wait_state_t state_q;
  wait_state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // A live load spends one cycle in IDLE with the pipeline frozen and a bubble
  // sent to WB; upstream holds the EX fields so WAIT completes it normally.
  // Stall is masked by reset so the request drops as soon as reset asserts.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.MemRd_EX && !bus.RPzero_EX && !reset) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`else
  assign stall  = 1'b0;
  assign bubble = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.RegWr_WB   <= 1'b0;
      bus.rd4        <= '0;
      bus.WBvalue_WB <= '0;
      bus.RPzero_WB  <= 1'b1;
    end else if (bubble) begin
      bus.RegWr_WB   <= 1'b0;
      bus.rd4        <= '0;
      bus.WBvalue_WB <= '0;
      bus.RPzero_WB  <= 1'b1;
    end else begin
      bus.RegWr_WB   <= reg_wr;
      bus.rd4        <= bus.rd3;
      bus.WBvalue_WB <= sel_value;
      bus.RPzero_WB  <= bus.RPzero_EX;
    end
  end

  assign bus.Rd_MEM       = bus.rd3;
  assign bus.RegWrite_MEM = reg_wr & ~stall;
  assign bus.Fwd_MEM      = sel_value;
  assign bus.Stall_MEM    = stall;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 Parameter MEM_DEPTH, default 64, number of 32-bit data-memory words.
REQ-002 Parameter ADDR_W, default 6, word-address width; log2(MEM_DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 RegWr_EX, MemWr_EX, MemRd_EX  in  1 each  control bits from the EX/MEM register.
REQ-006 WBdata_EX  in  2  write-back source: 00 ALU, 01 memory, 10 NPC, 11 reserved (treated as ALU).
REQ-007 ALUout_EX  in  32  ALU result / memory address; D  in  32  store data; npc3  in  32  next PC.
REQ-008 rd3  in  4  destination register; RPzero_EX  in  1  predicate-false/killed flag.
REQ-009 RegWr_WB  out  1; rd4  out  4; WBvalue_WB  out  32; RPzero_WB  out  1  MEM/WB register outputs.
REQ-010 Rd_MEM  out  4; RegWrite_MEM  out  1; Fwd_MEM  out  32  combinational forwarding taps to Hazard_Unit/EX.
REQ-011 Stall_MEM  out  1  request to freeze PC, IF/ID, ID/EX and EX/MEM; constant 0 when MEM_WAIT_EN is undefined.

Function
REQ-012 MemWr_final SHALL be MemWr_EX & ~RPzero_EX; the write occurs at the rising edge.
REQ-013 Memory address SHALL be ALUout_EX[ADDR_W-1:0]; upper bits are ignored, so addresses wrap modulo MEM_DEPTH.
REQ-014 Read data SHALL be combinational from the addressed word when MemRd_EX=1, and 0 otherwise.
REQ-015 Read of the word being written in the same cycle SHALL return the old contents.
REQ-016 Selected value SHALL be ALUout_EX (00/11), read data (01), or npc3 (10).
REQ-017 Without a stall, the MEM/WB register SHALL capture the selected value, rd3, RegWr_EX & ~RPzero_EX, and RPzero_EX each edge (latency 1 cycle).
REQ-018 Rd_MEM SHALL equal rd3, and RegWrite_MEM SHALL equal RegWr_EX & ~RPzero_EX & ~Stall_MEM.
REQ-019 Fwd_MEM SHALL equal the selected value of REQ-016.
REQ-020 RegWrite_MEM SHALL be 0 for loads until data is valid.
REQ-021 Stores SHALL NOT assert RegWr_WB unless RegWr_EX=1 (no implicit write-back).

Reset
REQ-022 While reset=1: RegWr_WB=0, rd4=0, WBvalue_WB=0, RPzero_WB=1, wait FSM=IDLE, Stall_MEM=0; memory contents are not cleared.
REQ-023 Reset asserted mid-wait SHALL abort the load immediately; no write-back occurs.

Configuration
REQ-024 Macro MEM_WAIT_EN: when defined, loads take 2 cycles via FSM states IDLE and WAIT.
REQ-025 FSM IDLE behaviour: when MemRd_EX=1 and RPzero_EX=0:
- Stall_MEM=1 (combinational).
- MEM/WB loads a bubble (RegWr_WB=0, RPzero_WB=1).
- Next state is WAIT.
REQ-026 FSM WAIT behaviour:
- Stall_MEM=0; EX inputs are held by upstream.
- Data is captured into MEM/WB.
- Next state is IDLE.
REQ-027 Killed loads (RPzero_EX=1) SHALL never enter WAIT; stores and ALU ops are never delayed.
REQ-028 Without MEM_WAIT_EN, the FSM SHALL be absent, Stall_MEM is tied to 0, and all accesses complete in 1 cycle.

Structure
REQ-029 A shared package SHALL hold WBdata encodings (WB_ALU, WB_MEM, WB_NPC) and FSM state encodings.
REQ-030 Data memory SHALL be the existing DataMemo sub-module, instantiated once; the FSM and MEM/WB register are local.

Verification
REQ-031 Store 0xAAAA5555 to ALUout=10, then load from 10 with WBdata=01, rd3=3, RegWr=1 -> next cycle WBvalue_WB=0xAAAA5555, rd4=3, RegWr_WB=1.
REQ-032 Store with RPzero_EX=1, D=0xFFFFFFFF to address 10, then load 10 -> 0xAAAA5555 (write suppressed).
REQ-033 ALUout=15, WBdata=00, rd3=5 -> Fwd_MEM=15, RegWrite_MEM=1 same cycle; next cycle WBvalue_WB=15. With WBdata=10 and npc3=7 -> WBvalue_WB=7.
REQ-034 Address 74 (0x4A) stores to word 10 (wrap) -> a load from 10 returns the stored value.
REQ-035 MEM_WAIT_EN defined, load from address 20 (0x12345678) -> cycle 1: Stall_MEM=1, RegWr_WB=0 next; cycle 2: Stall_MEM=0, WBvalue_WB=0x12345678 after the edge.
REQ-036 MEM_WAIT_EN defined, reset pulsed while in WAIT -> FSM=IDLE, RegWr_WB=0, RPzero_WB=1, no write-back.
